// File: rtl/pic_pkg.sv
// Shared types for the priority interrupt controller: acknowledge FSM states and EOI commands.
package pic_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAck1 = 2'd1,
    StAck2 = 2'd2
  } pic_state_e;

  typedef enum logic [1:0] {
    EoiNone    = 2'd0,
    EoiNonSpec = 2'd1,
    EoiSpec    = 2'd2
  } pic_eoi_e;

  // A specific EOI takes precedence if both strobes are raised together.
  function automatic pic_eoi_e eoi_decode(input logic ns, input logic sp);
    pic_eoi_e cmd;
    cmd = EoiNone;
    if (sp) begin
      cmd = EoiSpec;
    end else if (ns) begin
      cmd = EoiNonSpec;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational priority resolver: rotates by the current lowest-priority pointer, finds the
// highest pending unmasked request and highest in-service channel, and compares their ranks.
module pic_priority_resolver #(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned ID_W  = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] i_irr,
  input  logic [N_IRQ-1:0] i_imr,
  input  logic [N_IRQ-1:0] i_isr,
  input  logic             i_rotate,
  input  logic [ID_W-1:0]  i_lowest_id,
  output logic             o_req_hit,
  output logic [ID_W-1:0]  o_req_id,
  output logic             o_isr_hit,
  output logic [ID_W-1:0]  o_isr_id,
  output logic             o_eligible
);

  logic [N_IRQ-1:0] w_pend;
  logic [ID_W-1:0]  w_base;
  logic [ID_W-1:0]  w_idx;
  logic [ID_W-1:0]  w_req_rank;
  logic [ID_W-1:0]  w_isr_rank;

  assign w_pend = i_irr & ~i_imr;
  assign w_base = i_rotate ? (i_lowest_id + ID_W'(1)) : '0;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    o_req_hit  = 1'b0;
    o_req_id   = '0;
    o_isr_hit  = 1'b0;
    o_isr_id   = '0;
    w_req_rank = '0;
    w_isr_rank = '0;
    w_idx      = '0;
    for (int j = N_IRQ - 1; j >= 0; j--) begin
      w_idx = w_base + ID_W'(j);
      if (w_pend[w_idx]) begin
        o_req_hit  = 1'b1;
        o_req_id   = w_idx;
        w_req_rank = ID_W'(j);
      end
      if (i_isr[w_idx]) begin
        o_isr_hit  = 1'b1;
        o_isr_id   = w_idx;
        w_isr_rank = ID_W'(j);
      end
    end
    o_eligible = o_req_hit && (!o_isr_hit || (w_req_rank < w_isr_rank));
  end

endmodule

// File: rtl/pic_priority_core.sv
// 8259-style priority interrupt controller core: request synchronisation, IRR/ISR/IMR,
// fully nested priority with optional rotation, and a two-pulse acknowledge sequence.
module pic_priority_core
  import pic_pkg::*;
#(
  parameter int unsigned N_IRQ = 8,
  parameter int unsigned ID_W  = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] interrupt_request,
  input  logic             level_mode,
  input  logic             rotate_mode,
  input  logic             auto_eoi,
  input  logic             imr_wr,
  input  logic [N_IRQ-1:0] imr_data,
  input  logic [7:0]       vector_base,
  input  logic             int_ack,
  input  logic             eoi_ns,
  input  logic             eoi_sp,
  input  logic [ID_W-1:0]  eoi_id,
  output logic             interrupt_to_cpu,
  output logic [7:0]       vector_out,
  output logic             vector_valid,
  output logic [N_IRQ-1:0] irr_out,
  output logic [N_IRQ-1:0] isr_out,
  output logic [N_IRQ-1:0] imr_out
);

  logic [N_IRQ-1:0] r_sync1, r_sync2, r_sync3;
  logic [N_IRQ-1:0] r_irr, r_isr, r_imr;
  logic [ID_W-1:0]  r_lowest_id, r_id;
  logic             r_ack_q, r_spurious, r_int, r_vector_valid;
  logic [7:0]       r_vector;
  pic_state_e       r_state, w_state_d;

  logic             w_ack_ev, w_enter_ack1, w_load_vec, w_leave_ack2, w_int_d;
  logic             w_req_hit, w_isr_hit, w_eligible;
  logic [ID_W-1:0]  w_win_id, w_isr_top, w_lowest_d;
  logic [N_IRQ-1:0] w_irr_d, w_isr_d;
  pic_eoi_e         w_eoi_cmd;

  assign w_ack_ev  = r_ack_q & ~int_ack;
  assign w_eoi_cmd = eoi_decode(eoi_ns, eoi_sp);

  pic_priority_resolver #(
    .N_IRQ (N_IRQ),
    .ID_W  (ID_W)
  ) u_resolver (
    .i_irr       (r_irr),
    .i_imr       (r_imr),
    .i_isr       (r_isr),
    .i_rotate    (rotate_mode),
    .i_lowest_id (r_lowest_id),
    .o_req_hit   (w_req_hit),
    .o_req_id    (w_win_id),
    .o_isr_hit   (w_isr_hit),
    .o_isr_id    (w_isr_top),
    .o_eligible  (w_eligible)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_ack_ev) w_state_d = StAck1;
      StAck1:  if (w_ack_ev) w_state_d = StAck2;
      StAck2:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // The CPU request is only re-evaluated while idle and drops as soon as an ack begins.
  always_comb begin
    w_enter_ack1 = (r_state == StIdle) && w_ack_ev;
    w_load_vec   = (r_state == StAck1) && w_ack_ev;
    w_leave_ack2 = (r_state == StAck2);
    w_int_d      = (r_state == StIdle) && !w_ack_ev && w_eligible;
  end

  always_comb begin
    w_irr_d    = r_irr;
    w_isr_d    = r_isr;
    w_lowest_d = r_lowest_id;
    if (level_mode) begin
      w_irr_d = r_sync2;
    end else begin
      if (w_enter_ack1 && w_eligible) w_irr_d[w_win_id] = 1'b0;
      w_irr_d = w_irr_d | (r_sync2 & ~r_sync3);
    end
    case (w_eoi_cmd)
      EoiNonSpec: begin
        if (w_isr_hit) begin
          w_isr_d[w_isr_top] = 1'b0;
          if (rotate_mode) w_lowest_d = w_isr_top;
        end
      end
      EoiSpec: begin
        if (r_isr[eoi_id]) begin
          w_isr_d[eoi_id] = 1'b0;
          if (rotate_mode) w_lowest_d = eoi_id;
        end
      end
      default: ;
    endcase
    if (w_leave_ack2 && auto_eoi && !r_spurious) begin
      w_isr_d[r_id] = 1'b0;
      if (rotate_mode) w_lowest_d = r_id;
    end
    // Applied last so a set on ACK1 wins over a same-cycle clear of the same bit.
    if (w_enter_ack1 && w_eligible) w_isr_d[w_win_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1        <= '0;
      r_sync2        <= '0;
      r_sync3        <= '0;
      r_irr          <= '0;
      r_isr          <= '0;
      r_imr          <= '1;
      r_lowest_id    <= ID_W'(N_IRQ - 1);
      r_id           <= '0;
      r_spurious     <= 1'b0;
      r_ack_q        <= 1'b1;
      r_int          <= 1'b0;
      r_vector       <= '0;
      r_vector_valid <= 1'b0;
    end else begin
      r_sync1        <= interrupt_request;
      r_sync2        <= r_sync1;
      r_sync3        <= r_sync2;
      r_irr          <= w_irr_d;
      r_isr          <= w_isr_d;
      r_lowest_id    <= w_lowest_d;
      r_ack_q        <= int_ack;
      r_int          <= w_int_d;
      r_vector_valid <= w_load_vec;
      if (imr_wr) r_imr <= imr_data;
      if (w_enter_ack1) begin
        r_id       <= w_eligible ? w_win_id : ID_W'(N_IRQ - 1);
        r_spurious <= !w_eligible;
      end
      if (w_load_vec) r_vector <= {vector_base[7:ID_W], r_id};
    end
  end

  assign interrupt_to_cpu = r_int;
  assign vector_out       = r_vector;
  assign vector_valid     = r_vector_valid;
  assign irr_out          = r_irr;
  assign isr_out          = r_isr;
  assign imr_out          = r_imr;

endmodule

// File: tb/tb_pic_priority_core.sv
// Bench for pic_priority_core: rank-based reference model compared every cycle, plus
// directed scenarios with hand-computed vectors and register values.
module tb_pic_priority_core;

  localparam int N = 8;

  logic       clk, rst_n;
  logic [7:0] interrupt_request, imr_data, vector_base, vector_out;
  logic       level_mode, rotate_mode, auto_eoi, imr_wr, int_ack, eoi_ns, eoi_sp;
  logic [2:0] eoi_id;
  logic       interrupt_to_cpu, vector_valid;
  logic [7:0] irr_out, isr_out, imr_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] last_vec;
  int vv_count = 0;

  pic_priority_core #(.N_IRQ(N)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .interrupt_request (interrupt_request),
    .level_mode        (level_mode),
    .rotate_mode       (rotate_mode),
    .auto_eoi          (auto_eoi),
    .imr_wr            (imr_wr),
    .imr_data          (imr_data),
    .vector_base       (vector_base),
    .int_ack           (int_ack),
    .eoi_ns            (eoi_ns),
    .eoi_sp            (eoi_sp),
    .eoi_id            (eoi_id),
    .interrupt_to_cpu  (interrupt_to_cpu),
    .vector_out        (vector_out),
    .vector_valid      (vector_valid),
    .irr_out           (irr_out),
    .isr_out           (isr_out),
    .imr_out           (imr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_s1, m_s2, m_s3, m_irr, m_isr, m_imr, m_vec;
  int         m_lowest, m_phase, m_id;
  bit         m_spur, m_ack_prev, m_int, m_vv;

  // Priority rank: 0 is highest.
  function automatic int rank(input int i, input bit rot, input int low);
    return rot ? (i - low - 1 + N) % N : i;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int best_id, best_rk, top_id, top_rk;
    bit ack_ev, elig;
    logic [7:0] pend, nirr, nisr;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_s3 = 0; m_irr = 0; m_isr = 0; m_imr = 8'hFF; m_vec = 0;
      m_lowest = N - 1; m_phase = 0; m_id = 0; m_spur = 0; m_ack_prev = 1; m_int = 0; m_vv = 0;
    end else begin
      ack_ev = m_ack_prev && !int_ack;
      pend = m_irr & ~m_imr;
      best_id = 0; best_rk = N; top_id = 0; top_rk = N;
      for (int i = 0; i < N; i++) begin
        if (pend[i] && rank(i, rotate_mode, m_lowest) < best_rk) begin
          best_rk = rank(i, rotate_mode, m_lowest); best_id = i;
        end
        if (m_isr[i] && rank(i, rotate_mode, m_lowest) < top_rk) begin
          top_rk = rank(i, rotate_mode, m_lowest); top_id = i;
        end
      end
      elig = best_rk < top_rk;
      nirr = m_irr;
      nisr = m_isr;
      if (level_mode) nirr = m_s2;
      else begin
        if (m_phase == 0 && ack_ev && elig) nirr[best_id] = 1'b0;
        nirr = nirr | (m_s2 & ~m_s3);
      end
      if (eoi_sp) begin
        if (m_isr[eoi_id]) begin
          nisr[eoi_id] = 1'b0;
          if (rotate_mode) m_lowest = int'(eoi_id);
        end
      end else if (eoi_ns && top_rk < N) begin
        nisr[top_id] = 1'b0;
        if (rotate_mode) m_lowest = top_id;
      end
      m_int = (m_phase == 0) && !ack_ev && elig;
      m_vv = 0;
      case (m_phase)
        0: if (ack_ev) begin
          m_phase = 1;
          m_spur = !elig;
          m_id = elig ? best_id : N - 1;
          if (elig) nisr[best_id] = 1'b1;
        end
        1: if (ack_ev) begin
          m_phase = 2;
          m_vv = 1;
          m_vec = (vector_base & 8'hF8) | 8'(m_id);
        end
        default: begin
          m_phase = 0;
          if (auto_eoi && !m_spur) begin
            nisr[m_id] = 1'b0;
            if (rotate_mode) m_lowest = m_id;
          end
        end
      endcase
      if (m_imr != imr_data && imr_wr) m_imr = imr_data;
      m_irr = nirr;
      m_isr = nisr;
      m_ack_prev = int_ack;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = interrupt_request;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    check("model_irr", 32'(irr_out), 32'(m_irr));
    check("model_isr", 32'(isr_out), 32'(m_isr));
    check("model_imr", 32'(imr_out), 32'(m_imr));
    check("model_int", 32'(interrupt_to_cpu), 32'(m_int));
    check("model_vv", 32'(vector_valid), 32'(m_vv));
    if (m_vv) check("model_vec", 32'(vector_out), 32'(m_vec));
    if (vector_valid) begin
      last_vec = vector_out;
      vv_count++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b0; tick(1);
    int_ack = 1'b1; tick(1);
  endtask

  task automatic full_ack();
    pulse_ack(); pulse_ack(); tick(2);
  endtask

  task automatic irq_pulse(input logic [7:0] bits);
    interrupt_request = bits; tick(1);
    interrupt_request = 8'h00; tick(5);
  endtask

  task automatic do_eoi_ns();
    eoi_ns = 1'b1; tick(1);
    eoi_ns = 1'b0; tick(2);
  endtask

  task automatic write_imr(input logic [7:0] v);
    imr_data = v; imr_wr = 1'b1; tick(1);
    imr_wr = 1'b0; tick(1);
  endtask

  initial begin
    int vv_before;
    rst_n = 1'b0; interrupt_request = 0; level_mode = 0; rotate_mode = 0; auto_eoi = 0;
    imr_wr = 0; imr_data = 0; vector_base = 8'h20; int_ack = 1; eoi_ns = 0; eoi_sp = 0;
    eoi_id = 0;
    tick(2);
    check("rst_irr", 32'(irr_out), 32'h00);
    check("rst_isr", 32'(isr_out), 32'h00);
    check("rst_imr", 32'(imr_out), 32'hFF);
    check("rst_int", 32'(interrupt_to_cpu), 32'h0);
    check("rst_vec", 32'(vector_out), 32'h00);
    rst_n = 1'b1;
    tick(1);
    write_imr(8'h00);

    // Edge request on IR3: IRR after 3rd edge, CPU request after 4th.
    interrupt_request = 8'h08;
    tick(3);
    check("ir3_irr_e3", 32'(irr_out), 32'h08);
    check("ir3_int_e3", 32'(interrupt_to_cpu), 32'h0);
    tick(1);
    check("ir3_int_e4", 32'(interrupt_to_cpu), 32'h1);
    interrupt_request = 8'h00;
    full_ack();
    check("ir3_vec", 32'(last_vec), 32'h23);
    check("ir3_isr", 32'(isr_out), 32'h08);
    check("ir3_irr_clr", 32'(irr_out), 32'h00);
    do_eoi_ns();

    // IR1 and IR5 together in fixed mode.
    irq_pulse(8'h22);
    full_ack();
    check("ir1_vec", 32'(last_vec), 32'h21);
    check("ir5_blocked", 32'(interrupt_to_cpu), 32'h0);
    do_eoi_ns();
    tick(1);
    check("ir5_int", 32'(interrupt_to_cpu), 32'h1);
    full_ack();
    check("ir5_vec", 32'(last_vec), 32'h25);
    do_eoi_ns();

    // Rotation: after IR2 is serviced, IR3 outranks IR2.
    rotate_mode = 1'b1;
    irq_pulse(8'h04);
    full_ack();
    check("rot_ir2_vec", 32'(last_vec), 32'h22);
    do_eoi_ns();
    irq_pulse(8'h0C);
    full_ack();
    check("rot_ir3_vec", 32'(last_vec), 32'h23);
    do_eoi_ns();
    tick(1);
    full_ack();
    check("rot_ir2b_vec", 32'(last_vec), 32'h22);
    do_eoi_ns();
    rotate_mode = 1'b0;

    // Fully nested: IR2 in service blocks IR4, IR0 gets through.
    irq_pulse(8'h04);
    full_ack();
    check("nest_isr2", 32'(isr_out), 32'h04);
    irq_pulse(8'h10);
    check("nest_ir4_no_int", 32'(interrupt_to_cpu), 32'h0);
    irq_pulse(8'h01);
    check("nest_ir0_int", 32'(interrupt_to_cpu), 32'h1);
    full_ack();
    check("nest_ir0_vec", 32'(last_vec), 32'h20);
    check("nest_isr05", 32'(isr_out), 32'h05);
    do_eoi_ns();
    eoi_id = 3'd2; eoi_sp = 1'b1; tick(1);
    eoi_sp = 1'b0; tick(2);
    check("nest_sp_eoi", 32'(isr_out), 32'h00);
    full_ack();
    check("nest_ir4_vec", 32'(last_vec), 32'h24);
    do_eoi_ns();

    // Spurious ack, then auto-EOI.
    full_ack();
    check("spur_vec", 32'(last_vec), 32'h27);
    check("spur_isr", 32'(isr_out), 32'h00);
    auto_eoi = 1'b1;
    irq_pulse(8'h02);
    pulse_ack();
    check("aeoi_isr_set", 32'(isr_out), 32'h02);
    pulse_ack();
    tick(2);
    check("aeoi_vec", 32'(last_vec), 32'h21);
    check("aeoi_isr_clr", 32'(isr_out), 32'h00);
    auto_eoi = 1'b0;

    // Level mode: IRR follows the held line.
    level_mode = 1'b1;
    interrupt_request = 8'h40;
    tick(5);
    check("lvl_irr", 32'(irr_out), 32'h40);
    check("lvl_int", 32'(interrupt_to_cpu), 32'h1);
    full_ack();
    check("lvl_vec", 32'(last_vec), 32'h26);
    interrupt_request = 8'h00;
    tick(4);
    check("lvl_irr_drop", 32'(irr_out), 32'h00);
    do_eoi_ns();
    level_mode = 1'b0;

    // Reset in the middle of an acknowledge.
    irq_pulse(8'h08);
    pulse_ack();
    check("mid_isr", 32'(isr_out), 32'h08);
    vv_before = vv_count;
    rst_n = 1'b0;
    #1;
    check("mid_rst_irr", 32'(irr_out), 32'h00);
    check("mid_rst_isr", 32'(isr_out), 32'h00);
    check("mid_rst_imr", 32'(imr_out), 32'hFF);
    check("mid_rst_int", 32'(interrupt_to_cpu), 32'h0);
    check("mid_rst_vec", 32'(vector_out), 32'h00);
    check("mid_rst_vv", 32'(vector_valid), 32'h0);
    tick(2);
    rst_n = 1'b1;
    pulse_ack();
    tick(6);
    check("mid_no_vv", 32'(vv_count), 32'(vv_before));
    check("mid_imr_after", 32'(imr_out), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pic_priority_core.md
PIC_PRIORITY_CORE -- requirements
Module: pic_priority_core

Interface
REQ-001 Parameter N_IRQ, default 8, number of interrupt channels (legal 2..32, power of two).
REQ-002 Parameter ID_W, default $clog2(N_IRQ), channel-index width.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 interrupt_request  input  N_IRQ  raw, asynchronous channel requests.
REQ-006 level_mode  input  1  0 = edge-triggered requests, 1 = level-triggered.
REQ-007 rotate_mode  input  1  0 = fixed priority (bit 0 highest), 1 = automatic rotation.
REQ-008 auto_eoi  input  1  1 = in-service bit cleared automatically at end of acknowledge.
REQ-009 imr_wr / imr_data  input  1 / N_IRQ  mask-register write strobe and data.
REQ-010 vector_base  input  8  vector base; low ID_W bits ignored.
REQ-011 int_ack  input  1  active-low acknowledge from CPU, synchronous to clk.
REQ-012 eoi_ns / eoi_sp / eoi_id  input  1 / 1 / ID_W  non-specific EOI, specific EOI, target channel.
REQ-013 interrupt_to_cpu  output  1  registered interrupt request to CPU.
REQ-014 vector_out / vector_valid  output  8 / 1  acknowledged vector and its one-cycle qualifier.
REQ-015 irr_out / isr_out / imr_out  output  N_IRQ each  request, in-service and mask registers.

Function
REQ-016 Each request bit SHALL pass a 2-flop synchronizer; edge mode sets IRR on a 0->1 of the synchronized bit, level mode makes IRR track the synchronized bit.
REQ-017 Edge mode: a request first sampled high at rising edge k SHALL set IRR after edge k+2 and interrupt_to_cpu after edge k+3.
REQ-018 Masked channels SHALL still latch IRR but never contribute to interrupt_to_cpu or selection.
REQ-019 Priority order: fixed mode bit 0 highest; rotate mode the channel after pointer lowest_id is highest, wrapping modulo N_IRQ.
REQ-020 Fully nested: a pending unmasked request SHALL raise interrupt_to_cpu only if strictly higher priority than the highest ISR bit.
REQ-021 FSM states IDLE, ACK1, ACK2; an acknowledge event is int_ack 1->0 detected by a registered copy.
REQ-022 IDLE->ACK1 on ack event: latch winning id, set its ISR bit, clear its IRR bit (edge mode), drop interrupt_to_cpu next cycle.
REQ-023 No eligible request at ACK1 (spurious): id = N_IRQ-1, ISR unchanged.
REQ-024 ACK1->ACK2 on next ack event: vector_out = {vector_base[7:ID_W], id}, vector_valid high exactly one cycle; ACK2->IDLE next cycle.
REQ-025 auto_eoi=1: ISR bit of id cleared on ACK2->IDLE (not for spurious); rotate mode then sets lowest_id = id.
REQ-026 eoi_ns clears highest-priority ISR bit; eoi_sp clears ISR[eoi_id]; rotate mode sets lowest_id to cleared channel; EOI with empty ISR is a no-op.
REQ-027 EOI and ACK1 in the same cycle both apply; if they target the same bit, set wins.
REQ-028 imr_wr takes effect next cycle, at any FSM state; it never aborts an acknowledge in progress.
REQ-029 Ack event in ACK2 is ignored; interrupt_to_cpu re-evaluated only in IDLE.

Reset
REQ-030 rst_n low SHALL immediately clear IRR, ISR, synchronizers, interrupt_to_cpu, vector_out, vector_valid; IMR = all ones; lowest_id = N_IRQ-1; state IDLE.
REQ-031 Reset mid-acknowledge SHALL abandon the cycle; no vector_valid after release.

Structure
REQ-032 Shared package pic_pkg SHALL hold the FSM state enum and EOI command constants.
REQ-033 Sub-module pic_priority_resolver (combinational, parametrised N_IRQ): rotate, priority-encode, compare against ISR.

Verification
REQ-034 Reset, imr 0x00, edge IR3 0->1 -> interrupt_to_cpu after 4th edge; two acks, base 0x20 -> vector 0x23, ISR 0x08.
REQ-035 IR1 and IR5 simultaneous, fixed -> vector id 1; after eoi_ns, IR5 acknowledged -> id 5.
REQ-036 rotate_mode, IR2 served and EOI'd, then IR2 and IR3 pending -> IR3 wins.
REQ-037 ISR bit 2 set, IR4 pending -> no interrupt_to_cpu; IR0 pending -> asserted.
REQ-038 Ack with no request -> id 7 (N_IRQ=8), ISR unchanged; auto_eoi=1 -> ISR clears after ACK2.
REQ-039 rst_n low during ACK1 -> all outputs zero, IMR 0xFF, no vector_valid.
